// File: rtl/mastermind_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mastermind_engine                                           |
// | Purpose  : Parametrised Mastermind core. Holds the secret code, takes  |
// |            guesses over valid/ready, scores black/white sequentially   |
// |            (one exact pass, then one pass per colour) and keeps a      |
// |            per-turn history for readback.                              |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mastermind_engine #(
  parameter int NUM_PEGS   = 4,
  parameter int COLOR_BITS = 3,
  parameter int MAX_TURNS  = 8,
  localparam int PW = $clog2(NUM_PEGS + 1),
  localparam int TW = $clog2(MAX_TURNS + 1),
  localparam int CW = NUM_PEGS * COLOR_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic [CW-1:0] code_in,
  input  logic          guess_valid,
  output logic          guess_ready,
  input  logic [CW-1:0] guess_in,
  output logic          result_valid,
  output logic [PW-1:0] black,
  output logic [PW-1:0] white,
  output logic [TW-1:0] turn,
  output logic          game_over,
  output logic          game_won,
  input  logic [TW-1:0] hist_sel,
  output logic [CW-1:0] hist_guess,
  output logic [PW-1:0] hist_black,
  output logic [PW-1:0] hist_white
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLAY   = 3'd1,
    S_EXACT  = 3'd2,
    S_COLOR  = 3'd3,
    S_FINISH = 3'd4,
    S_OVER   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         code_q, code_d;
  logic [CW-1:0]         guess_q, guess_d;
  logic [COLOR_BITS-1:0] color_q, color_d;
  logic [PW-1:0]         black_acc_q, black_acc_d;
  logic [PW-1:0]         white_acc_q, white_acc_d;
  logic                  guess_ready_q, guess_ready_d;
  logic                  result_valid_q, result_valid_d;
  logic [PW-1:0]         black_q, black_d;
  logic [PW-1:0]         white_q, white_d;
  logic [TW-1:0]         turn_q, turn_d;
  logic                  game_over_q, game_over_d;
  logic                  game_won_q, game_won_d;
  logic [CW-1:0]         hist_guess_q [MAX_TURNS];
  logic [CW-1:0]         hist_guess_d [MAX_TURNS];
  logic [PW-1:0]         hist_black_q [MAX_TURNS];
  logic [PW-1:0]         hist_black_d [MAX_TURNS];
  logic [PW-1:0]         hist_white_q [MAX_TURNS];
  logic [PW-1:0]         hist_white_d [MAX_TURNS];

  logic [PW-1:0]         exact_cnt;
  logic [PW-1:0]         code_cc;
  logic [PW-1:0]         guess_cc;
  logic [PW-1:0]         min_cc;

  // Per-cycle counts: exact matches, and occurrences of the current colour in code and guess
  always_comb begin
    exact_cnt = '0;
    code_cc   = '0;
    guess_cc  = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (guess_q[i*COLOR_BITS +: COLOR_BITS] == code_q[i*COLOR_BITS +: COLOR_BITS])
        exact_cnt = exact_cnt + PW'(1);
      if (code_q[i*COLOR_BITS +: COLOR_BITS] == color_q)
        code_cc = code_cc + PW'(1);
      if (guess_q[i*COLOR_BITS +: COLOR_BITS] == color_q)
        guess_cc = guess_cc + PW'(1);
    end
    min_cc = (code_cc < guess_cc) ? code_cc : guess_cc;
  end

  // Next-state and next-output logic; new_game overrides everything, including mid-scoring
  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    guess_d        = guess_q;
    color_d        = color_q;
    black_acc_d    = black_acc_q;
    white_acc_d    = white_acc_q;
    result_valid_d = 1'b0;
    black_d        = black_q;
    white_d        = white_q;
    turn_d         = turn_q;
    game_over_d    = game_over_q;
    game_won_d     = game_won_q;
    hist_guess_d   = hist_guess_q;
    hist_black_d   = hist_black_q;
    hist_white_d   = hist_white_q;

    if (new_game) begin
      state_d     = S_PLAY;
      code_d      = code_in;
      color_d     = '0;
      black_acc_d = '0;
      white_acc_d = '0;
      black_d     = '0;
      white_d     = '0;
      turn_d      = '0;
      game_over_d = 1'b0;
      game_won_d  = 1'b0;
      for (int i = 0; i < MAX_TURNS; i++) begin
        hist_guess_d[i] = '0;
        hist_black_d[i] = '0;
        hist_white_d[i] = '0;
      end
    end else begin
      case (state_q)
        S_PLAY: begin
          if (guess_valid) begin
            guess_d = guess_in;
            state_d = S_EXACT;
          end
        end
        S_EXACT: begin
          black_acc_d = exact_cnt;
          white_acc_d = '0;
          color_d     = '0;
          state_d     = S_COLOR;
        end
        S_COLOR: begin
          // white_acc collects total colour matches; exact ones are removed at FINISH
          white_acc_d = white_acc_q + min_cc;
          color_d     = color_q + COLOR_BITS'(1);
          if (color_q == {COLOR_BITS{1'b1}})
            state_d = S_FINISH;
        end
        S_FINISH: begin
          black_d        = black_acc_q;
          white_d        = white_acc_q - black_acc_q;
          result_valid_d = 1'b1;
          turn_d         = turn_q + TW'(1);
          for (int i = 0; i < MAX_TURNS; i++) begin
            if (turn_q == TW'(i)) begin
              hist_guess_d[i] = guess_q;
              hist_black_d[i] = black_acc_q;
              hist_white_d[i] = white_acc_q - black_acc_q;
            end
          end
          if (black_acc_q == PW'(NUM_PEGS)) begin
            game_won_d  = 1'b1;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else if (turn_q == TW'(MAX_TURNS - 1)) begin
            game_won_d  = 1'b0;
            game_over_d = 1'b1;
            state_d     = S_OVER;
          end else begin
            state_d = S_PLAY;
          end
        end
        S_IDLE, S_OVER: ;
        default: state_d = S_IDLE;
      endcase
    end

    guess_ready_d = (state_d == S_PLAY);
  end

  // State and registered outputs; asynchronous active-low reset clears everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      code_q         <= '0;
      guess_q        <= '0;
      color_q        <= '0;
      black_acc_q    <= '0;
      white_acc_q    <= '0;
      guess_ready_q  <= 1'b0;
      result_valid_q <= 1'b0;
      black_q        <= '0;
      white_q        <= '0;
      turn_q         <= '0;
      game_over_q    <= 1'b0;
      game_won_q     <= 1'b0;
      for (int i = 0; i < MAX_TURNS; i++) begin
        hist_guess_q[i] <= '0;
        hist_black_q[i] <= '0;
        hist_white_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      guess_q        <= guess_d;
      color_q        <= color_d;
      black_acc_q    <= black_acc_d;
      white_acc_q    <= white_acc_d;
      guess_ready_q  <= guess_ready_d;
      result_valid_q <= result_valid_d;
      black_q        <= black_d;
      white_q        <= white_d;
      turn_q         <= turn_d;
      game_over_q    <= game_over_d;
      game_won_q     <= game_won_d;
      hist_guess_q   <= hist_guess_d;
      hist_black_q   <= hist_black_d;
      hist_white_q   <= hist_white_d;
    end
  end

  // History readback: only entries already written this game are visible
  always_comb begin
    hist_guess = '0;
    hist_black = '0;
    hist_white = '0;
    for (int i = 0; i < MAX_TURNS; i++) begin
      if ((hist_sel == TW'(i)) && (TW'(i) < turn_q)) begin
        hist_guess = hist_guess_q[i];
        hist_black = hist_black_q[i];
        hist_white = hist_white_q[i];
      end
    end
  end

  assign guess_ready  = guess_ready_q;
  assign result_valid = result_valid_q;
  assign black        = black_q;
  assign white        = white_q;
  assign turn         = turn_q;
  assign game_over    = game_over_q;
  assign game_won     = game_won_q;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mastermind_engine                                        |
// | Purpose  : Directed self-checking bench for mastermind_engine (4-peg   |
// |            default instance plus a 6-peg, 2-bit-colour instance).      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_mastermind_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Default instance: 4 pegs, 3-bit colours, 8 turns
  logic        new_game = 1'b0, guess_valid = 1'b0;
  logic [11:0] code_in = '0, guess_in = '0, hist_guess;
  logic        guess_ready, result_valid, game_over, game_won;
  logic [2:0]  black, white, hist_black, hist_white;
  logic [3:0]  turn, hist_sel = '0;

  mastermind_engine dut (
    .clk(clk), .rst(rst), .new_game(new_game), .code_in(code_in),
    .guess_valid(guess_valid), .guess_ready(guess_ready), .guess_in(guess_in),
    .result_valid(result_valid), .black(black), .white(white), .turn(turn),
    .game_over(game_over), .game_won(game_won), .hist_sel(hist_sel),
    .hist_guess(hist_guess), .hist_black(hist_black), .hist_white(hist_white)
  );

  // Second instance: 6 pegs, 2-bit colours
  logic        new_game2 = 1'b0, guess_valid2 = 1'b0;
  logic [11:0] code_in2 = '0, guess_in2 = '0, hist_guess2;
  logic        guess_ready2, result_valid2, game_over2, game_won2;
  logic [2:0]  black2, white2, hist_black2, hist_white2;
  logic [3:0]  turn2, hist_sel2 = '0;

  mastermind_engine #(.NUM_PEGS(6), .COLOR_BITS(2), .MAX_TURNS(8)) dut2 (
    .clk(clk), .rst(rst), .new_game(new_game2), .code_in(code_in2),
    .guess_valid(guess_valid2), .guess_ready(guess_ready2), .guess_in(guess_in2),
    .result_valid(result_valid2), .black(black2), .white(white2), .turn(turn2),
    .game_over(game_over2), .game_won(game_won2), .hist_sel(hist_sel2),
    .hist_guess(hist_guess2), .hist_black(hist_black2), .hist_white(hist_white2)
  );

  localparam logic [11:0] CODE_A = {3'd3, 3'd1, 3'd4, 3'd1};

  // Pulse new_game on the default instance; caller sits 1ns after a posedge
  task automatic start_game(input logic [11:0] c);
    code_in  = c;
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  // Present a guess, return cycles from accepting edge to result_valid (-1 on timeout)
  task automatic play_guess(input logic [11:0] g, output int lat);
    bit done;
    lat  = -1;
    done = 1'b0;
    for (int k = 0; k < 20 && !guess_ready; k++) begin @(posedge clk); #1; end
    guess_in    = g;
    guess_valid = 1'b1;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(posedge clk); #1;
      if (result_valid) begin lat = k; done = 1'b1; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({guess_ready, result_valid, black, white, turn, game_over, game_won} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b b=%0d w=%0d t=%0d over=%b won=%b want all 0",
               guess_ready, result_valid, black, white, turn, game_over, game_won);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    start_game(CODE_A);
    tests_run++;
    if (guess_ready !== 1'b1) begin tests_failed++; $display("FAIL newgame_ready: got %b want 1", guess_ready); end
    tests_run++;
    if (turn !== 4'd0 || game_over !== 1'b0) begin
      tests_failed++; $display("FAIL newgame_turn_over: got t=%0d over=%b want 0/0", turn, game_over);
    end
    hist_sel = 4'd0; #1;
    tests_run++;
    if ({hist_guess, hist_black, hist_white} !== '0) begin
      tests_failed++; $display("FAIL newgame_hist: got g=%h b=%0d w=%0d want 0", hist_guess, hist_black, hist_white);
    end
  endtask

  task automatic test_scoring;
    int lat;
    play_guess({3'd1, 3'd3, 3'd1, 3'd4}, lat);
    tests_run++;
    if (lat !== 10) begin tests_failed++; $display("FAIL latency_4peg: got %0d want 10", lat); end
    tests_run++;
    if (black !== 3'd0 || white !== 3'd4 || turn !== 4'd1) begin
      tests_failed++; $display("FAIL score_1: got b=%0d w=%0d t=%0d want 0/4/1", black, white, turn);
    end
    hist_sel = 4'd0; #1;
    tests_run++;
    if (hist_guess !== {3'd1, 3'd3, 3'd1, 3'd4} || hist_black !== 3'd0 || hist_white !== 3'd4) begin
      tests_failed++; $display("FAIL hist_0: got g=%h b=%0d w=%0d want 2cc/0/4", hist_guess, hist_black, hist_white);
    end
    hist_sel = 4'd1; #1;
    tests_run++;
    if ({hist_guess, hist_black, hist_white} !== '0) begin
      tests_failed++; $display("FAIL hist_unwritten: got g=%h b=%0d w=%0d want 0", hist_guess, hist_black, hist_white);
    end
  endtask

  task automatic test_win;
    int lat, rv_seen;
    play_guess({3'd3, 3'd1, 3'd4, 3'd2}, lat);
    tests_run++;
    if (black !== 3'd3 || white !== 3'd0 || game_over !== 1'b0) begin
      tests_failed++; $display("FAIL score_3black: got b=%0d w=%0d over=%b want 3/0/0", black, white, game_over);
    end
    play_guess(CODE_A, lat);
    tests_run++;
    if (black !== 3'd4 || white !== 3'd0 || game_won !== 1'b1 || game_over !== 1'b1 || guess_ready !== 1'b0) begin
      tests_failed++; $display("FAIL win: got b=%0d w=%0d won=%b over=%b rdy=%b want 4/0/1/1/0",
                               black, white, game_won, game_over, guess_ready);
    end
    rv_seen = 0;
    guess_in = CODE_A; guess_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (result_valid) rv_seen++; end
    guess_valid = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (result_valid) rv_seen++; end
    tests_run++;
    if (turn !== 4'd3 || rv_seen !== 0) begin
      tests_failed++; $display("FAIL over_ignores_guess: got t=%0d rv=%0d want 3/0", turn, rv_seen);
    end
  endtask

  task automatic test_loss;
    int lat;
    start_game(CODE_A);
    for (int i = 0; i < 8; i++) begin
      play_guess(12'h000, lat);
      tests_run++;
      if (black !== 3'd0 || white !== 3'd0 || lat !== 10) begin
        tests_failed++; $display("FAIL loss_guess_%0d: got b=%0d w=%0d lat=%0d want 0/0/10", i, black, white, lat);
      end
      if (i < 7) begin
        tests_run++;
        if (game_over !== 1'b0) begin tests_failed++; $display("FAIL early_over_%0d: got %b want 0", i, game_over); end
      end
    end
    tests_run++;
    if (game_over !== 1'b1 || game_won !== 1'b0 || turn !== 4'd8 || guess_ready !== 1'b0) begin
      tests_failed++; $display("FAIL loss_end: got over=%b won=%b t=%0d rdy=%b want 1/0/8/0",
                               game_over, game_won, turn, guess_ready);
    end
    hist_sel = 4'd7; #1;
    tests_run++;
    if ({hist_guess, hist_black, hist_white} !== '0) begin
      tests_failed++; $display("FAIL hist_7: got g=%h b=%0d w=%0d want 0/0/0", hist_guess, hist_black, hist_white);
    end
  endtask

  task automatic test_abort;
    int lat, rv_seen;
    start_game(CODE_A);
    guess_in = {3'd2, 3'd2, 3'd1, 3'd1}; guess_valid = 1'b1;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // new_game 4 cycles after acceptance, with a guess_valid alongside that must be ignored
    code_in = {3'd2, 3'd2, 3'd2, 3'd2}; new_game = 1'b1; guess_valid = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0; guess_valid = 1'b0;
    rv_seen = 0;
    repeat (15) begin @(posedge clk); #1; if (result_valid) rv_seen++; end
    tests_run++;
    if (rv_seen !== 0 || turn !== 4'd0 || guess_ready !== 1'b1) begin
      tests_failed++; $display("FAIL abort: got rv=%0d t=%0d rdy=%b want 0/0/1", rv_seen, turn, guess_ready);
    end
    hist_sel = 4'd0; #1;
    tests_run++;
    if ({hist_guess, hist_black, hist_white} !== '0) begin
      tests_failed++; $display("FAIL abort_hist: got g=%h want 0", hist_guess);
    end
    play_guess({3'd2, 3'd2, 3'd1, 3'd1}, lat);
    tests_run++;
    if (black !== 3'd2 || white !== 3'd0 || turn !== 4'd1) begin
      tests_failed++; $display("FAIL abort_newcode: got b=%0d w=%0d t=%0d want 2/0/1", black, white, turn);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    start_game(CODE_A);
    play_guess({3'd3, 3'd1, 3'd4, 3'd2}, lat);
    guess_in = 12'h000; guess_valid = 1'b1;
    @(posedge clk); #1;
    guess_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({guess_ready, result_valid, black, white, turn, game_over, game_won} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got rdy=%b rv=%b b=%0d w=%0d t=%0d over=%b won=%b want all 0",
               guess_ready, result_valid, black, white, turn, game_over, game_won);
    end
    hist_sel = 4'd0; #1;
    tests_run++;
    if ({hist_guess, hist_black, hist_white} !== '0) begin
      tests_failed++; $display("FAIL async_reset_hist: got g=%h b=%0d want 0", hist_guess, hist_black);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    guess_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    guess_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    tests_run++;
    if (guess_ready !== 1'b0 || turn !== 4'd0 || result_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset: got rdy=%b t=%0d rv=%b want 0/0/0", guess_ready, turn, result_valid);
    end
  endtask

  task automatic test_params;
    int  lat;
    bit  done;
    code_in2  = {2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    new_game2 = 1'b1;
    @(posedge clk); #1;
    new_game2 = 1'b0;
    guess_in2 = {2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2}; guess_valid2 = 1'b1;
    @(posedge clk); #1;
    guess_valid2 = 1'b0;
    lat = -1; done = 1'b0;
    for (int k = 1; k <= 30 && !done; k++) begin
      @(posedge clk); #1;
      if (result_valid2) begin lat = k; done = 1'b1; end
    end
    tests_run++;
    if (lat !== 6) begin tests_failed++; $display("FAIL latency_6peg: got %0d want 6", lat); end
    tests_run++;
    if (black2 !== 3'd1 || white2 !== 3'd4 || turn2 !== 4'd1) begin
      tests_failed++; $display("FAIL score_6peg: got b=%0d w=%0d t=%0d want 1/4/1", black2, white2, turn2);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_scoring();
    test_win();
    test_loss();
    test_abort();
    test_async_reset();
    test_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
